priv_vector_csr_spec: RTL and testbench

- Parametrised next-generation vector CSR unit for the priv_1_12 block: vstart, vxsat, vxrm, vcsr, vl, vtype, vlenb.
- Executes vsetvl/vsetvli/vsetivli with a one-cycle request/response handshake: vtype legality check, VLMAX computation, vl = min(AVL, VLMAX).
- Holds up to NSPEC speculative vl/vtype updates in an in-order queue. Entries are retired into architectural state on commit and discarded on flush.

---
 rtl/priv_vector_csr_spec_if.sv | 31 +++
 rtl/priv_vector_csr_spec.sv | 213 +++++++++++++++++++++
 tb/tb_priv_vector_csr_spec.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/priv_vector_csr_spec_if.sv
// Bus bundle for the vector CSR unit: CSR access port plus the vsetvl
// request/response handshake.
interface priv_vector_csr_spec_if #(
    parameter int XLEN = 32
);
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_ack;
    logic            csr_invalid;

    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_mode;
    logic [XLEN-1:0] req_avl;
    logic [XLEN-1:0] req_vtype;
    logic            resp_valid;
    logic [XLEN-1:0] resp_vl;
    logic            resp_vill;

    modport master (
        output csr_addr, csr_we, csr_wdata, req_valid, req_mode, req_avl, req_vtype,
        input  csr_rdata, csr_ack, csr_invalid, req_ready, resp_valid, resp_vl, resp_vill
    );

    modport slave (
        input  csr_addr, csr_we, csr_wdata, req_valid, req_mode, req_avl, req_vtype,
        output csr_rdata, csr_ack, csr_invalid, req_ready, resp_valid, resp_vl, resp_vill
    );
endinterface

// File: rtl/priv_vector_csr_spec.sv
// Vector CSR unit: vstart/vxsat/vxrm/vcsr/vl/vtype/vlenb with vsetvl execution
// and an in-order queue of speculative vl/vtype updates retired on commit.
module priv_vector_csr_spec #(
    parameter int XLEN  = 32,
    parameter int VLEN  = 128,
    parameter int ELEN  = 32,
    parameter int NSPEC = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    priv_vector_csr_spec_if.slave bus,
    input  logic                  sat_set,
    input  logic                  commit,
    input  logic                  flush,
    input  logic                  vec_retire,
    output logic [XLEN-1:0]       spec_vl,
    output logic [XLEN-1:0]       spec_vtype,
    output logic [XLEN-1:0]       arch_vl,
    output logic [XLEN-1:0]       arch_vtype,
    output logic [XLEN-1:0]       vstart_o
);
    localparam int VW  = $clog2(VLEN) + 1;
    localparam int VSW = $clog2(VLEN);
    localparam int CW  = $clog2(NSPEC + 1);
    localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

    logic [VSW-1:0]  vstart_q, vstart_d;
    logic            vxsat_q, vxsat_d;
    logic [1:0]      vxrm_q, vxrm_d;
    logic [XLEN-1:0] arch_vl_q, arch_vl_d;
    logic [XLEN-1:0] arch_vtype_q, arch_vtype_d;
    logic [XLEN-1:0] q_vl_q [NSPEC];
    logic [XLEN-1:0] q_vl_d [NSPEC];
    logic [XLEN-1:0] q_vtype_q [NSPEC];
    logic [XLEN-1:0] q_vtype_d [NSPEC];
    logic [CW-1:0]   count_q, count_d;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_vl_q;
    logic            resp_vill_q;

    logic            accept, do_commit;
    logic            new_vill;
    logic [XLEN-1:0] new_vl, new_vtype;
    logic [VW-1:0]   new_vlmax, spec_vlmax;
    logic            unused_bits;

    function automatic logic [VW-1:0] calc_vlmax(input logic [2:0] vsew, input logic [2:0] vlmul);
        logic [VW-1:0] base;
        logic [VW-1:0] res;
        base = VW'(VLEN) >> ({1'b0, vsew} + 4'd3);
        case (vlmul)
            3'b000, 3'b001, 3'b010, 3'b011: res = base << vlmul[1:0];
            3'b111:  res = base >> 1;
            3'b110:  res = base >> 2;
            3'b101:  res = base >> 3;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic vtype_legal(input logic [XLEN-1:0] vt);
        int  sew;
        int  frac_shift;
        logic ok;
        sew        = 8 << vt[5:3];
        frac_shift = 4 - int'(vt[1:0]);
        ok = 1'b1;
        if (|vt[XLEN-2:8])       ok = 1'b0;
        if (vt[2:0] == 3'b100)   ok = 1'b0;
        if (sew > ELEN)          ok = 1'b0;
        // 101/110/111 are LMUL 1/8, 1/4, 1/2: SEW must fit in ELEN*LMUL
        if (vt[2] && (vt[1:0] != 2'b00) && (sew > (ELEN >> frac_shift))) ok = 1'b0;
        return ok;
    endfunction

    assign unused_bits = ^{bus.csr_wdata[XLEN-1:VSW], bus.req_vtype[XLEN-1]};

    assign bus.req_ready = (count_q < CW'(NSPEC));
    assign accept        = bus.req_valid && bus.req_ready && !flush;
    assign do_commit     = commit && (count_q != '0);

    always_comb begin
        spec_vl    = arch_vl_q;
        spec_vtype = arch_vtype_q;
        for (int i = 0; i < NSPEC; i++) begin
            if (count_q == CW'(i + 1)) begin
                spec_vl    = q_vl_q[i];
                spec_vtype = q_vtype_q[i];
            end
        end
    end

    always_comb begin
        new_vlmax  = calc_vlmax(bus.req_vtype[5:3], bus.req_vtype[2:0]);
        spec_vlmax = calc_vlmax(spec_vtype[5:3], spec_vtype[2:0]);
        new_vill   = !vtype_legal(bus.req_vtype);
        new_vl     = '0;
        case (bus.req_mode)
            2'b01: new_vl = XLEN'(new_vlmax);
            2'b10: begin
                // keeping vl is only meaningful if the SEW/LMUL ratio is preserved
                if (spec_vtype[XLEN-1] || (new_vlmax != spec_vlmax)) new_vill = 1'b1;
                else new_vl = spec_vl;
            end
            default: new_vl = (bus.req_avl < XLEN'(new_vlmax)) ? bus.req_avl : XLEN'(new_vlmax);
        endcase
        if (new_vill) new_vl = '0;
        new_vtype = new_vill ? VILL_VTYPE : {{(XLEN-8){1'b0}}, bus.req_vtype[7:0]};
    end

    always_comb begin
        q_vl_d       = q_vl_q;
        q_vtype_d    = q_vtype_q;
        count_d      = count_q;
        arch_vl_d    = arch_vl_q;
        arch_vtype_d = arch_vtype_q;
        if (do_commit) begin
            arch_vl_d    = q_vl_q[0];
            arch_vtype_d = q_vtype_q[0];
            for (int i = 0; i < NSPEC - 1; i++) begin
                q_vl_d[i]    = q_vl_q[i+1];
                q_vtype_d[i] = q_vtype_q[i+1];
            end
            count_d = count_q - CW'(1);
        end
        if (accept) begin
            for (int i = 0; i < NSPEC; i++) begin
                if (count_d == CW'(i)) begin
                    q_vl_d[i]    = new_vl;
                    q_vtype_d[i] = new_vtype;
                end
            end
            count_d = count_d + CW'(1);
        end
        if (flush) count_d = '0;
    end

    always_comb begin
        vstart_d = vstart_q;
        vxsat_d  = vxsat_q;
        vxrm_d   = vxrm_q;
        if (bus.csr_we) begin
            case (bus.csr_addr)
                12'h008: vstart_d = bus.csr_wdata[VSW-1:0];
                12'h009: vxsat_d  = bus.csr_wdata[0];
                12'h00A: vxrm_d   = bus.csr_wdata[1:0];
                12'h00F: begin
                    vxsat_d = bus.csr_wdata[0];
                    vxrm_d  = bus.csr_wdata[2:1];
                end
                default: ;
            endcase
        end
        vxsat_d = vxsat_d | sat_set;
        if (vec_retire) vstart_d = '0;
    end

    always_comb begin
        bus.csr_rdata = '0;
        bus.csr_ack   = 1'b1;
        case (bus.csr_addr)
            12'h008: bus.csr_rdata = XLEN'(vstart_q);
            12'h009: bus.csr_rdata = XLEN'(vxsat_q);
            12'h00A: bus.csr_rdata = XLEN'(vxrm_q);
            12'h00F: bus.csr_rdata = XLEN'({vxrm_q, vxsat_q});
            12'hC20: bus.csr_rdata = arch_vl_q;
            12'hC21: bus.csr_rdata = arch_vtype_q;
            12'hC22: bus.csr_rdata = XLEN'(VLEN / 8);
            default: bus.csr_ack   = 1'b0;
        endcase
    end

    assign bus.csr_invalid = bus.csr_we && (bus.csr_addr >= 12'hC20) && (bus.csr_addr <= 12'hC22);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vstart_q     <= '0;
            vxsat_q      <= 1'b0;
            vxrm_q       <= '0;
            arch_vl_q    <= '0;
            arch_vtype_q <= VILL_VTYPE;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_vl_q    <= '0;
            resp_vill_q  <= 1'b0;
            for (int i = 0; i < NSPEC; i++) begin
                q_vl_q[i]    <= '0;
                q_vtype_q[i] <= '0;
            end
        end else begin
            vstart_q     <= vstart_d;
            vxsat_q      <= vxsat_d;
            vxrm_q       <= vxrm_d;
            arch_vl_q    <= arch_vl_d;
            arch_vtype_q <= arch_vtype_d;
            count_q      <= count_d;
            resp_valid_q <= accept;
            if (accept) begin
                resp_vl_q   <= new_vl;
                resp_vill_q <= new_vill;
            end
            q_vl_q    <= q_vl_d;
            q_vtype_q <= q_vtype_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_vl    = resp_vl_q;
    assign bus.resp_vill  = resp_vill_q;
    assign arch_vl        = arch_vl_q;
    assign arch_vtype     = arch_vtype_q;
    assign vstart_o       = XLEN'(vstart_q);
endmodule

// File: tb/tb_priv_vector_csr_spec.sv
// Directed bench for the vector CSR unit: a vsetvl vector table with
// hand-computed results, then queue, CSR-priority and reset sequences.
module tb_priv_vector_csr_spec;
    localparam logic [31:0] VILL = 32'h8000_0000;

    logic        CLK;
    logic        nRST;
    logic        sat_set, commit, flush, vec_retire;
    logic [31:0] spec_vl, spec_vtype, arch_vl, arch_vtype, vstart_o;
    logic [31:0] rd;
    int          checks;
    int          failures;

    priv_vector_csr_spec_if #(.XLEN(32)) bus ();

    priv_vector_csr_spec #(.XLEN(32), .VLEN(128), .ELEN(32), .NSPEC(2)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .bus        (bus),
        .sat_set    (sat_set),
        .commit     (commit),
        .flush      (flush),
        .vec_retire (vec_retire),
        .spec_vl    (spec_vl),
        .spec_vtype (spec_vtype),
        .arch_vl    (arch_vl),
        .arch_vtype (arch_vtype),
        .vstart_o   (vstart_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] avl;
        logic [31:0] vtype;
        logic [31:0] exp_vl;
        logic        exp_vill;
        logic [31:0] exp_vtype;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
        bus.csr_addr = a;
        #1;
        d = bus.csr_rdata;
    endtask

    task automatic set_req(input logic [1:0] m, input logic [31:0] avl, input logic [31:0] vt);
        bus.req_valid = 1'b1;
        bus.req_mode  = m;
        bus.req_avl   = avl;
        bus.req_vtype = vt;
    endtask

    initial begin
        checks = 0; failures = 0;
        nRST = 1'b0; sat_set = 0; commit = 0; flush = 0; vec_retire = 0;
        bus.csr_addr = 12'h000; bus.csr_we = 0; bus.csr_wdata = 0;
        bus.req_valid = 0; bus.req_mode = 0; bus.req_avl = 0; bus.req_vtype = 0;

        // mode, avl, vtype, expected vl, expected vill, expected vtype
        vecs[0]  = '{2'b00, 32'd10,       32'h010, 32'd4,   1'b0, 32'h010};
        vecs[1]  = '{2'b00, 32'd3,        32'h010, 32'd3,   1'b0, 32'h010};
        vecs[2]  = '{2'b10, 32'd0,        32'h00F, 32'd3,   1'b0, 32'h00F};
        vecs[3]  = '{2'b10, 32'd0,        32'h008, 32'd0,   1'b1, VILL};
        vecs[4]  = '{2'b01, 32'd0,        32'h003, 32'd128, 1'b0, 32'h003};
        vecs[5]  = '{2'b01, 32'd0,        32'h018, 32'd0,   1'b1, VILL};
        vecs[6]  = '{2'b00, 32'd100,      32'h005, 32'd0,   1'b1, VILL};
        vecs[7]  = '{2'b00, 32'd20,       32'h0C8, 32'd8,   1'b0, 32'h0C8};
        vecs[8]  = '{2'b00, 32'd5,        32'h100, 32'd0,   1'b1, VILL};
        vecs[9]  = '{2'b00, 32'd7,        32'h004, 32'd0,   1'b1, VILL};
        vecs[10] = '{2'b00, 32'd0,        32'h000, 32'd0,   1'b0, 32'h000};
        vecs[11] = '{2'b00, 32'd16,       32'h000, 32'd16,  1'b0, 32'h000};
        vecs[12] = '{2'b00, 32'd17,       32'h000, 32'd16,  1'b0, 32'h000};
        vecs[13] = '{2'b00, 32'd9,        32'h006, 32'd4,   1'b0, 32'h006};
        vecs[14] = '{2'b00, 32'd9,        32'h00E, 32'd0,   1'b1, VILL};
        vecs[15] = '{2'b01, 32'd0,        32'h017, 32'd0,   1'b1, VILL};
        vecs[16] = '{2'b00, 32'hFFFFFFFF, 32'h012, 32'd16,  1'b0, 32'h012};
        vecs[17] = '{2'b10, 32'd0,        32'h009, 32'd16,  1'b0, 32'h009};

        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // reset state
        csr_read(12'hC21, rd); chk("rst_vtype", rd, VILL);
        csr_read(12'hC22, rd); chk("rst_vlenb", rd, 32'd16);
        chk("rst_ack", {31'd0, bus.csr_ack}, 32'd1);
        csr_read(12'h123, rd); chk("unowned_rdata", rd, 32'd0);
        chk("unowned_ack", {31'd0, bus.csr_ack}, 32'd0);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_arch_vl", arch_vl, 32'd0);
        chk("rst_spec_vtype", spec_vtype, VILL);
        chk("rst_vstart", vstart_o, 32'd0);

        // table: issue, check response and spec state, commit, check arch
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            set_req(vecs[i].mode, vecs[i].avl, vecs[i].vtype);
            #1 chk($sformatf("v%0d_ready", i), {31'd0, bus.req_ready}, 32'd1);
            @(negedge CLK);
            bus.req_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_resp_valid", i), {31'd0, bus.resp_valid}, 32'd1);
            chk($sformatf("v%0d_resp_vl", i), bus.resp_vl, vecs[i].exp_vl);
            chk($sformatf("v%0d_resp_vill", i), {31'd0, bus.resp_vill}, {31'd0, vecs[i].exp_vill});
            chk($sformatf("v%0d_spec_vl", i), spec_vl, vecs[i].exp_vl);
            chk($sformatf("v%0d_spec_vtype", i), spec_vtype, vecs[i].exp_vtype);
            commit = 1'b1;
            @(negedge CLK);
            commit = 1'b0;
            #1;
            chk($sformatf("v%0d_resp_drop", i), {31'd0, bus.resp_valid}, 32'd0);
            chk($sformatf("v%0d_arch_vl", i), arch_vl, vecs[i].exp_vl);
            chk($sformatf("v%0d_arch_vtype", i), arch_vtype, vecs[i].exp_vtype);
        end

        // fill the queue, stall a third request, then commit+flush together
        @(negedge CLK);
        set_req(2'b00, 32'd10, 32'h010);
        @(negedge CLK);
        set_req(2'b00, 32'd2, 32'h000);
        #1;
        chk("q1_resp_vl", bus.resp_vl, 32'd4);
        chk("q1_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("q1_arch_vl", arch_vl, 32'd16);
        @(negedge CLK);
        set_req(2'b00, 32'd5, 32'h010);
        #1;
        chk("q2_resp_vl", bus.resp_vl, 32'd2);
        chk("q2_spec_vl", spec_vl, 32'd2);
        chk("q2_full_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge CLK);
        #1;
        chk("q3_stalled", {31'd0, bus.resp_valid}, 32'd0);
        chk("q3_spec_vl", spec_vl, 32'd2);
        bus.req_valid = 1'b0;
        commit = 1'b1;
        flush  = 1'b1;
        @(negedge CLK);
        commit = 1'b0;
        flush  = 1'b0;
        #1;
        chk("cf_arch_vl", arch_vl, 32'd4);
        chk("cf_arch_vtype", arch_vtype, 32'h010);
        chk("cf_spec_vl", spec_vl, 32'd4);
        chk("cf_spec_vtype", spec_vtype, 32'h010);
        chk("cf_ready", {31'd0, bus.req_ready}, 32'd1);

        // request in a flush cycle is dropped
        @(negedge CLK);
        set_req(2'b00, 32'd1, 32'h010);
        flush = 1'b1;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("fl_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("fl_spec_vl", spec_vl, 32'd4);

        // push and commit in the same cycle keep the count
        @(negedge CLK);
        set_req(2'b00, 32'd2, 32'h010);
        @(negedge CLK);
        set_req(2'b00, 32'd3, 32'h000);
        commit = 1'b1;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        #1;
        chk("pc_arch_vl", arch_vl, 32'd2);
        chk("pc_spec_vl", spec_vl, 32'd3);
        chk("pc_resp_vl", bus.resp_vl, 32'd3);
        chk("pc_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge CLK);
        commit = 1'b0;
        #1;
        chk("pc2_arch_vl", arch_vl, 32'd3);
        chk("pc2_arch_vtype", arch_vtype, 32'h000);
        commit = 1'b1;
        @(negedge CLK);
        commit = 1'b0;
        #1;
        chk("empty_commit_vl", arch_vl, 32'd3);
        chk("empty_commit_vtype", arch_vtype, 32'h000);

        // CSR writes and priorities
        bus.csr_addr = 12'hC20; bus.csr_we = 1'b1; bus.csr_wdata = 32'd99;
        #1 chk("ro_invalid", {31'd0, bus.csr_invalid}, 32'd1);
        @(negedge CLK);
        bus.csr_addr = 12'h008; bus.csr_wdata = 32'h85;
        #1 chk("rw_not_invalid", {31'd0, bus.csr_invalid}, 32'd0);
        @(negedge CLK);
        bus.csr_we = 1'b0;
        #1;
        chk("ro_vl_kept", arch_vl, 32'd3);
        chk("vstart_trunc", vstart_o, 32'd5);
        csr_read(12'h008, rd); chk("vstart_read", rd, 32'd5);

        @(negedge CLK);
        bus.csr_addr = 12'h00F; bus.csr_we = 1'b1; bus.csr_wdata = 32'h6;
        sat_set = 1'b1;
        @(negedge CLK);
        bus.csr_we = 1'b0; sat_set = 1'b0;
        csr_read(12'h00F, rd); chk("vcsr_sat", rd, 32'h7);
        csr_read(12'h00A, rd); chk("vxrm", rd, 32'h3);
        csr_read(12'h009, rd); chk("vxsat", rd, 32'h1);

        @(negedge CLK);
        bus.csr_addr = 12'h009; bus.csr_we = 1'b1; bus.csr_wdata = 32'h0;
        @(negedge CLK);
        bus.csr_we = 1'b0;
        csr_read(12'h00F, rd); chk("vcsr_clr_sat", rd, 32'h6);

        @(negedge CLK);
        bus.csr_addr = 12'h008; bus.csr_we = 1'b1; bus.csr_wdata = 32'd5;
        vec_retire = 1'b1;
        @(negedge CLK);
        bus.csr_we = 1'b0; vec_retire = 1'b0;
        #1 chk("vstart_retire", vstart_o, 32'd0);
        csr_read(12'hC20, rd); chk("read_vl", rd, 32'd3);

        // reset in the middle of a pending response
        @(negedge CLK);
        bus.csr_addr = 12'h008; bus.csr_we = 1'b1; bus.csr_wdata = 32'd9;
        set_req(2'b00, 32'd10, 32'h010);
        @(posedge CLK);
        #2;
        bus.req_valid = 1'b0; bus.csr_we = 1'b0;
        chk("pre_rst_resp", {31'd0, bus.resp_valid}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("mid_rst_spec_vl", spec_vl, 32'd0);
        chk("mid_rst_vtype", arch_vtype, VILL);
        chk("mid_rst_vstart", vstart_o, 32'd0);
        csr_read(12'h00F, rd); chk("mid_rst_vcsr", rd, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        chk("post_rst_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("post_rst_spec_vtype", spec_vtype, VILL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
